// File: rtl/lda_sweep_ctrl_if.sv
// lda_sweep_ctrl_if
//   Bundles the token/length memory read ports, the sampler handshake and the
//   topic write-back port of the LDA sweep controller.
//   master : controller side (drives addresses, sampler operands, write-back)
//   slave  : memory/sampler side
interface lda_sweep_ctrl_if #(
  parameter int TOK_AW = 17,
  parameter int DOC_AW = 10,
  parameter int DW     = 16,
  parameter int LEN_W  = 32
);
  // memory read side
  logic [TOK_AW-1:0] o_tok_raddr;
  logic [DW-1:0]     i_word_rdata;
  logic [DW-1:0]     i_topic_rdata;
  logic [DOC_AW-1:0] o_len_raddr;
  logic [LEN_W-1:0]  i_len_rdata;
  // sampler handshake
  logic              o_smp_start;
  logic [DOC_AW-1:0] o_smp_doc;
  logic [DW-1:0]     o_smp_word;
  logic [DW-1:0]     o_smp_topic;
  logic [LEN_W-1:0]  o_smp_len;
  logic              i_smp_done;
  logic [DW-1:0]     i_smp_topic;
  // topic write-back
  logic              o_tok_we;
  logic [TOK_AW-1:0] o_tok_waddr;
  logic [DW-1:0]     o_tok_wdata;

  modport master (
    output o_tok_raddr, o_len_raddr, o_smp_start, o_smp_doc, o_smp_word,
           o_smp_topic, o_smp_len, o_tok_we, o_tok_waddr, o_tok_wdata,
    input  i_word_rdata, i_topic_rdata, i_len_rdata, i_smp_done, i_smp_topic
  );

  modport slave (
    input  o_tok_raddr, o_len_raddr, o_smp_start, o_smp_doc, o_smp_word,
           o_smp_topic, o_smp_len, o_tok_we, o_tok_waddr, o_tok_wdata,
    output i_word_rdata, i_topic_rdata, i_len_rdata, i_smp_done, i_smp_topic
  );
endinterface

// File: rtl/lda_sweep_ctrl.sv
// lda_sweep_ctrl
//   Walks all tokens of a corpus for a number of sweeps. Per token it reads
//   word/topic/doc-length, runs the external sampler, and writes the new topic
//   back. Empty documents are skipped without consuming a token.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (master)        memory reads, sampler handshake, topic write-back
//   i_start             run request (accepted only when idle)
//   i_num_tokens        tokens per sweep, latched on accepted start
//   i_num_sweeps        sweep count (0 means 1), latched on accepted start
//   o_sweep             current sweep index (holds last index after a run)
//   o_changes           topic changes in the last completed sweep
//   o_busy / o_done     busy level / one-cycle completion pulse
// Build option:
//   LDA_CHANGE_CNT_EN   when defined, counts topic changes per sweep;
//                       otherwise o_changes is tied to 0.
module lda_sweep_ctrl #(
  parameter int TOK_AW = 17,
  parameter int DOC_AW = 10,
  parameter int DW     = 16,
  parameter int LEN_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lda_sweep_ctrl_if.master  bus,
  input  logic              i_start,
  input  logic [TOK_AW:0]   i_num_tokens,
  input  logic [7:0]        i_num_sweeps,
  output logic [7:0]        o_sweep,
  output logic [TOK_AW:0]   o_changes,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_SAMPLE, S_WRITE, S_ADVANCE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [TOK_AW-1:0] tok_q, tok_d;
  logic [DOC_AW-1:0] doc_q, doc_d;
  logic [LEN_W-1:0]  wid_q, wid_d;
  logic [DW-1:0]     word_q, word_d;
  logic [DW-1:0]     topic_q, topic_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DW-1:0]     new_topic_q, new_topic_d;
  logic [TOK_AW:0]   ntok_q, ntok_d;
  logic [7:0]        nsw_q, nsw_d;
  logic [7:0]        sweep_q, sweep_d;
  logic              smp_start_q, smp_start_d;
  logic              tok_we_q, tok_we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              last_tok_s;
`ifdef LDA_CHANGE_CNT_EN
  logic [TOK_AW:0]   chg_cnt_q, chg_cnt_d;
  logic [TOK_AW:0]   changes_q, changes_d;
`endif

  assign last_tok_s = ({1'b0, tok_q} == (ntok_q - (TOK_AW+1)'(1)));

  // next-state and datapath updates
  always_comb begin
    state_d     = state_q;
    tok_d       = tok_q;
    doc_d       = doc_q;
    wid_d       = wid_q;
    word_d      = word_q;
    topic_d     = topic_q;
    len_d       = len_q;
    new_topic_d = new_topic_q;
    ntok_d      = ntok_q;
    nsw_d       = nsw_q;
    sweep_d     = sweep_q;
    smp_start_d = 1'b0;
    tok_we_d    = 1'b0;
    done_d      = 1'b0;
`ifdef LDA_CHANGE_CNT_EN
    chg_cnt_d   = chg_cnt_q;
    changes_d   = changes_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          ntok_d  = i_num_tokens;
          nsw_d   = (i_num_sweeps == 8'd0) ? 8'd1 : i_num_sweeps;
          sweep_d = 8'd0;
          tok_d   = '0;
          doc_d   = '0;
          wid_d   = '0;
`ifdef LDA_CHANGE_CNT_EN
          chg_cnt_d = '0;
`endif
          if (i_num_tokens == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        word_d  = bus.i_word_rdata;
        topic_d = bus.i_topic_rdata;
        len_d   = bus.i_len_rdata;
        if (bus.i_len_rdata == '0) begin
          // empty document: move to the next one, same token
          doc_d   = doc_q + DOC_AW'(1);
          state_d = S_FETCH;
        end else begin
          state_d     = S_SAMPLE;
          smp_start_d = 1'b1;
        end
      end
      S_SAMPLE: begin
        // smp_start_q marks the first SAMPLE cycle; a done there is stale
        if (bus.i_smp_done && !smp_start_q) begin
          new_topic_d = bus.i_smp_topic;
          state_d     = S_WRITE;
          tok_we_d    = 1'b1;
        end else begin
          state_d = S_SAMPLE;
        end
      end
      S_WRITE: begin
`ifdef LDA_CHANGE_CNT_EN
        if (new_topic_q != topic_q) begin
          chg_cnt_d = chg_cnt_q + (TOK_AW+1)'(1);
        end else begin
          chg_cnt_d = chg_cnt_q;
        end
`endif
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (last_tok_s) begin
          tok_d = '0;
          doc_d = '0;
          wid_d = '0;
`ifdef LDA_CHANGE_CNT_EN
          changes_d = chg_cnt_q;
          chg_cnt_d = '0;
`endif
          if (sweep_q == (nsw_q - 8'd1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            sweep_d = sweep_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          tok_d = tok_q + TOK_AW'(1);
          if ((wid_q + LEN_W'(1)) == len_q) begin
            wid_d = '0;
            doc_d = doc_q + DOC_AW'(1);
          end else begin
            wid_d = wid_q + LEN_W'(1);
          end
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // state, datapath and registered output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tok_q       <= '0;
      doc_q       <= '0;
      wid_q       <= '0;
      word_q      <= '0;
      topic_q     <= '0;
      len_q       <= '0;
      new_topic_q <= '0;
      ntok_q      <= '0;
      nsw_q       <= 8'd0;
      sweep_q     <= 8'd0;
      smp_start_q <= 1'b0;
      tok_we_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef LDA_CHANGE_CNT_EN
      chg_cnt_q   <= '0;
      changes_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tok_q       <= tok_d;
      doc_q       <= doc_d;
      wid_q       <= wid_d;
      word_q      <= word_d;
      topic_q     <= topic_d;
      len_q       <= len_d;
      new_topic_q <= new_topic_d;
      ntok_q      <= ntok_d;
      nsw_q       <= nsw_d;
      sweep_q     <= sweep_d;
      smp_start_q <= smp_start_d;
      tok_we_q    <= tok_we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef LDA_CHANGE_CNT_EN
      chg_cnt_q   <= chg_cnt_d;
      changes_q   <= changes_d;
`endif
    end
  end

  assign bus.o_tok_raddr = tok_q;
  assign bus.o_len_raddr = doc_q;
  assign bus.o_smp_start = smp_start_q;
  assign bus.o_smp_doc   = doc_q;
  assign bus.o_smp_word  = word_q;
  assign bus.o_smp_topic = topic_q;
  assign bus.o_smp_len   = len_q;
  assign bus.o_tok_we    = tok_we_q;
  assign bus.o_tok_waddr = tok_q;
  assign bus.o_tok_wdata = new_topic_q;
  assign o_sweep         = sweep_q;
  assign o_busy          = busy_q;
  assign o_done          = done_q;
`ifdef LDA_CHANGE_CNT_EN
  assign o_changes       = changes_q;
`else
  assign o_changes       = '0;
`endif

endmodule

// File: tb/tb_lda_sweep_ctrl.sv
// Self-checking bench for lda_sweep_ctrl: table of run configurations checked
// against a scoreboard of expected write-backs, plus hand-written sequences
// for zero-token runs, spurious sampler pulses, busy starts and mid-run reset.
module tb_lda_sweep_ctrl;
  localparam int TOK_AW = 17;
  localparam int DOC_AW = 10;
  localparam int DW     = 16;
  localparam int LEN_W  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  logic [TOK_AW:0]   i_num_tokens;
  logic [7:0]        i_num_sweeps;
  logic [7:0]        o_sweep;
  logic [TOK_AW:0]   o_changes;
  logic              o_busy;
  logic              o_done;

  lda_sweep_ctrl_if #(.TOK_AW(TOK_AW), .DOC_AW(DOC_AW), .DW(DW), .LEN_W(LEN_W)) bus ();

  lda_sweep_ctrl #(.TOK_AW(TOK_AW), .DOC_AW(DOC_AW), .DW(DW), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .i_start      (i_start),
    .i_num_tokens (i_num_tokens),
    .i_num_sweeps (i_num_sweeps),
    .o_sweep      (o_sweep),
    .o_changes    (o_changes),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  always #5 clk = ~clk;

  // memory models: synchronous read, topic memory takes write-backs
  logic [DW-1:0]    wmem [16];
  logic [DW-1:0]    tinit[16];
  logic [DW-1:0]    tmem [16];
  logic [LEN_W-1:0] lmem [8];
  logic             mem_load;
  logic [DW-1:0]    word_rd, topic_rd;
  logic [LEN_W-1:0] len_rd;

  always @(posedge clk) begin
    word_rd  <= wmem[bus.o_tok_raddr[3:0]];
    topic_rd <= tmem[bus.o_tok_raddr[3:0]];
    len_rd   <= lmem[bus.o_len_raddr[2:0]];
    if (mem_load) begin
      for (int i = 0; i < 16; i++) tmem[i] <= tinit[i];
    end else if (bus.o_tok_we) begin
      tmem[bus.o_tok_waddr[3:0]] <= bus.o_tok_wdata;
    end
  end

  // sampler model: done 3 cycles after start; mode 1 keeps topic of odd words
  logic [1:0]    smp_cnt = 2'd0;
  logic          smp_done_m = 1'b0;
  logic [DW-1:0] smp_topic_m = '0;
  logic          smp_mode;
  logic          force_done;

  always @(posedge clk) begin
    smp_done_m <= 1'b0;
    if (bus.o_smp_start) begin
      smp_cnt <= 2'd3;
    end else if (smp_cnt != 2'd0) begin
      smp_cnt <= smp_cnt - 2'd1;
      if (smp_cnt == 2'd1) begin
        smp_done_m  <= 1'b1;
        smp_topic_m <= (smp_mode && bus.o_smp_word[0]) ? bus.o_smp_topic
                                                        : bus.o_smp_topic + 16'd1;
      end
    end
  end

  assign bus.i_word_rdata  = word_rd;
  assign bus.i_topic_rdata = topic_rd;
  assign bus.i_len_rdata   = len_rd;
  assign bus.i_smp_done    = smp_done_m | force_done;
  assign bus.i_smp_topic   = force_done ? 16'hBEEF : smp_topic_m;

  typedef struct {
    int nt; int ns; int l0; int l1; int l2; int l3;
    bit mode; bit inj; int exp_writes; int exp_last_sweep; int exp_chg;
  } case_t;

  typedef struct { int addr; int data; int doc; int sweep; } wr_t;

  case_t tbl[7];
  wr_t   exp_q[$];
  int    nchecks = 0;
  int    nerrors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_mem(input case_t c);
    lmem[0] = c.l0; lmem[1] = c.l1; lmem[2] = c.l2; lmem[3] = c.l3;
    for (int i = 4; i < 8; i++) lmem[i] = 32'd1;
    for (int i = 0; i < 16; i++) begin
      wmem[i]  = DW'(i);
      tinit[i] = DW'(16 + 3 * i);
    end
    smp_mode = c.mode;
    @(negedge clk) mem_load = 1'b1;
    @(negedge clk) mem_load = 1'b0;
  endtask

  // reference walk over documents producing the expected write-backs
  task automatic build_expect(input case_t c);
    int mtop[16];
    int ns_eff, doc, wid, nw;
    for (int i = 0; i < 16; i++) mtop[i] = 16 + 3 * i;
    ns_eff = (c.ns == 0) ? 1 : c.ns;
    for (int s = 0; s < ns_eff; s++) begin
      doc = 0; wid = 0;
      for (int t = 0; t < c.nt; t++) begin
        while (lmem[doc] == 0) doc++;
        nw = (c.mode && (t % 2 == 1)) ? mtop[t] : ((mtop[t] + 1) & 16'hFFFF);
        exp_q.push_back('{addr: t, data: nw, doc: doc, sweep: s});
        mtop[t] = nw;
        wid++;
        if (wid == int'(lmem[doc])) begin wid = 0; doc++; end
      end
    end
  endtask

  task automatic run_case(input int idx, input case_t c);
    int  n_we, n_start;
    bit  seen_done;
    wr_t e;
    load_mem(c);
    exp_q.delete();
    build_expect(c);
    n_we = 0; n_start = 0; seen_done = 1'b0;
    i_num_tokens = (TOK_AW+1)'(c.nt);
    i_num_sweeps = 8'(c.ns);
    i_start = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      i_start    = 1'b0;
      force_done = 1'b0;
      if (bus.o_tok_we) begin
        n_we++;
        if (exp_q.size() == 0) begin
          chk($sformatf("case%0d unexpected write", idx), 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("case%0d waddr", idx), bus.o_tok_waddr, e.addr);
          chk($sformatf("case%0d wdata", idx), bus.o_tok_wdata, e.data);
          chk($sformatf("case%0d smp_doc", idx), bus.o_smp_doc, e.doc);
          chk($sformatf("case%0d sweep", idx), o_sweep, e.sweep);
        end
      end
      if (bus.o_smp_start) begin
        n_start++;
        if (c.inj) begin
          // stale done coinciding with start, plus a start while busy
          force_done   = 1'b1;
          i_start      = 1'b1;
          i_num_tokens = (TOK_AW+1)'(7);
          i_num_sweeps = 8'd3;
        end
      end
      if (o_done) begin
        seen_done = 1'b1;
        break;
      end
    end
    chk($sformatf("case%0d done seen", idx), seen_done, 1);
    chk($sformatf("case%0d queue left", idx), exp_q.size(), 0);
    chk($sformatf("case%0d writes", idx), n_we, c.exp_writes);
    chk($sformatf("case%0d smp starts", idx), n_start, c.exp_writes);
    chk($sformatf("case%0d last sweep", idx), o_sweep, c.exp_last_sweep);
`ifdef LDA_CHANGE_CNT_EN
    chk($sformatf("case%0d changes", idx), o_changes, c.exp_chg);
`else
    chk($sformatf("case%0d changes", idx), o_changes, 0);
`endif
    @(negedge clk);
    chk($sformatf("case%0d done pulse width", idx), o_done, 0);
    chk($sformatf("case%0d idle busy", idx), o_busy, 0);
  endtask

  initial begin
    int  n_we;
    bit  seen;
    rst_n = 1'b0; i_start = 1'b0; i_num_tokens = '0; i_num_sweeps = 8'd0;
    force_done = 1'b0; mem_load = 1'b0; smp_mode = 1'b0;
    for (int i = 0; i < 16; i++) begin wmem[i] = '0; tinit[i] = '0; end
    for (int i = 0; i < 8; i++) lmem[i] = 32'd1;

    //              nt ns l0 l1 l2 l3 mode inj wr last chg
    tbl[0] = '{4, 1, 2, 2, 1, 1, 1'b0, 1'b0, 4, 0, 4};
    tbl[1] = '{3, 2, 3, 1, 1, 1, 1'b0, 1'b0, 6, 1, 3};
    tbl[2] = '{3, 1, 0, 3, 1, 1, 1'b0, 1'b0, 3, 0, 3};
    tbl[3] = '{4, 1, 2, 2, 1, 1, 1'b1, 1'b0, 4, 0, 2};
    tbl[4] = '{2, 0, 1, 1, 1, 1, 1'b0, 1'b0, 2, 0, 2};
    tbl[5] = '{5, 1, 1, 0, 2, 2, 1'b0, 1'b0, 5, 0, 5};
    tbl[6] = '{4, 1, 2, 2, 1, 1, 1'b0, 1'b1, 4, 0, 4};

    // reset state
    #1;
    chk("reset busy", o_busy, 0);
    chk("reset done", o_done, 0);
    chk("reset we", bus.o_tok_we, 0);
    chk("reset smp_start", bus.o_smp_start, 0);
    chk("reset sweep", o_sweep, 0);
    chk("reset raddr", bus.o_tok_raddr, 0);
    chk("reset changes", o_changes, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // zero tokens: DONE straight from IDLE, pulse in the cycle after start
    i_num_tokens = '0; i_num_sweeps = 8'd1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("zero tok done", o_done, 1);
    chk("zero tok busy", o_busy, 1);
    chk("zero tok smp_start", bus.o_smp_start, 0);
    @(negedge clk);
    chk("zero tok done cleared", o_done, 0);
    chk("zero tok idle", o_busy, 0);
    chk("zero tok we", bus.o_tok_we, 0);

    // spurious sampler done while idle
    force_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle spurious busy", o_busy, 0);
      chk("idle spurious we", bus.o_tok_we, 0);
    end
    force_done = 1'b0;

    // reset in the middle of SAMPLE
    load_mem(tbl[0]);
    i_num_tokens = (TOK_AW+1)'(4); i_num_sweeps = 8'd1; i_start = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      i_start = 1'b0;
      if (bus.o_smp_start) begin seen = 1'b1; break; end
    end
    chk("midrun reached sample", seen, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun reset busy", o_busy, 0);
    chk("midrun reset smp_start", bus.o_smp_start, 0);
    chk("midrun reset we", bus.o_tok_we, 0);
    chk("midrun reset smp_len", bus.o_smp_len, 0);
    chk("midrun reset smp_word", bus.o_smp_word, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_we = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.o_tok_we) n_we++;
      if (o_busy) seen = 1'b1;
    end
    chk("post reset writes", n_we, 0);
    chk("post reset busy", seen, 0);

    // table of full runs
    for (int k = 0; k < 7; k++) run_case(k, tbl[k]);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
